// File: rtl/digit_serial_multiplier_if.sv
// Handshake bundle between the operand source, the digit-serial multiplier
// and the reduction stage. Ports: in_valid/in_ready/a/b, out_valid/out_ready/product, busy.
interface digit_serial_multiplier_if #(
    parameter int WIDTH = 256
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/digit_serial_multiplier.sv
// Digit-serial unsigned multiplier: full 2*WIDTH product, one DIGIT_W digit of b per cycle.
// Ports: clk, reset (async, active-low), bus (slave: operands in, product out, busy).
// Optional `DIGIT_SKIP_EN: finish early once the remaining b digits (or a) are zero.
package elliptic_curve_structs;
    localparam int P_WIDTH = 256;
endpackage

module digit_serial_multiplier
    import elliptic_curve_structs::*;
#(
    parameter int WIDTH   = P_WIDTH,
    parameter int DIGIT_W = 16
) (
    input  logic clk,
    input  logic reset,
    digit_serial_multiplier_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT_W;
    localparam int CW   = $clog2(NDIG) + 1;
    localparam int PW   = 2 * WIDTH;

    generate
        if (WIDTH % DIGIT_W != 0) begin : g_bad_digit
            $error("WIDTH must be an integer multiple of DIGIT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [PW-1:0]    r_a;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_product;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    w_pp;
    logic [PW-1:0]    w_sum;
    logic             w_last;

    // r_a is pre-shifted, so the partial product lands at its final weight.
    assign w_pp  = r_a * PW'(r_b[DIGIT_W-1:0]);
    assign w_sum = r_acc + w_pp;

`ifdef DIGIT_SKIP_EN
    // Once no nonzero digit remains after this one, acc + w_pp is final.
    assign w_last = (r_cnt == CW'(NDIG - 1))
                 || ((r_b >> DIGIT_W) == '0)
                 || (r_a == '0);
`else
    assign w_last = (r_cnt == CW'(NDIG - 1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        unique case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    w_next = MULT;
                end
            end
            MULT: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_a   <= PW'(bus.a);
            r_b   <= bus.b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == MULT) begin
            r_acc <= w_sum;
            r_a   <= r_a << DIGIT_W;
            r_b   <= r_b >> DIGIT_W;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_product <= w_sum;
            end
        end
    end

    assign bus.product = r_product;
endmodule

// File: tb/tb_digit_serial_multiplier.sv
// Bench for digit_serial_multiplier: 16/4 directed cases and 256/16 random stream.
// Expected products go into queues at drive time and are popped at output.
module tb_digit_serial_multiplier;
    typedef logic [511:0] v_t;

`ifdef DIGIT_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int LAT = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    digit_serial_multiplier_if #(.WIDTH(16))  if16 ();
    digit_serial_multiplier_if #(.WIDTH(256)) if256 ();

    digit_serial_multiplier #(.WIDTH(16), .DIGIT_W(4)) u_dut16 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if16)
    );

    digit_serial_multiplier #(.WIDTH(256), .DIGIT_W(16)) u_dut256 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if256)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] q16[$];
    v_t q256[$];

    task automatic check(input string tag, input v_t obs, input v_t exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
        @(negedge clk);
        check("send_irdy", v_t'(if16.in_ready), v_t'(1));
        if16.in_valid = 1'b1;
        if16.a = a;
        if16.b = b;
        q16.push_back(exp);
        @(posedge clk);
        #1 if16.in_valid = 1'b0;
    endtask

    task automatic wait16(input string tag, input int exp_lat);
        int lat = 0;
        while (!if16.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, v_t'(lat), v_t'(exp_lat));
        check({tag, "_busy"}, v_t'(if16.busy), v_t'(1));
        check({tag, "_irdy"}, v_t'(if16.in_ready), v_t'(0));
    endtask

    task automatic pop16(input string tag, output logic [31:0] exp);
        if (q16.size() == 0) begin
            check({tag, "_sb_empty"}, v_t'(0), v_t'(1));
            exp = '0;
        end else begin
            exp = q16.pop_front();
        end
    endtask

    task automatic recv16(input string tag, input int exp_lat);
        logic [31:0] exp;
        wait16(tag, exp_lat);
        pop16(tag, exp);
        check({tag, "_prod"}, v_t'(if16.product), v_t'(exp));
        if16.out_ready = 1'b1;
        @(posedge clk);
        #1 if16.out_ready = 1'b0;
        check({tag, "_ov_drop"}, v_t'(if16.out_valid), v_t'(0));
        check({tag, "_irdy_back"}, v_t'(if16.in_ready), v_t'(1));
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    task automatic drive256();
        int i = 0;
        logic [255:0] a;
        logic [255:0] b;
        for (int c = 0; c < 4000 && i < 100; c++) begin
            @(negedge clk);
            if (if256.in_ready) begin
                if (i == 0) begin
                    a = '1;
                    b = '1;
                end else begin
                    a = rnd256();
                    b = rnd256();
                end
                if256.in_valid = 1'b1;
                if256.a = a;
                if256.b = b;
                q256.push_back({256'b0, a} * {256'b0, b});
                i++;
            end else begin
                if256.in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1 if256.in_valid = 1'b0;
    endtask

    task automatic mon256();
        int n = 0;
        int cyc = 0;
        int last = -1;
        v_t exp;
        while (n < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (if256.out_valid && if256.out_ready) begin
                if (q256.size() == 0) begin
                    check("p256_sb_empty", v_t'(0), v_t'(1));
                    exp = '0;
                end else begin
                    exp = q256.pop_front();
                end
                check("p256", if256.product, exp);
`ifndef DIGIT_SKIP_EN
                if (last >= 0) begin
                    check("gap256", v_t'(cyc - last), v_t'(18));
                end
`endif
                last = cyc;
                n++;
            end
        end
        check("n256", v_t'(n), v_t'(100));
    endtask

    initial begin
        logic [31:0] exp;
        if16.in_valid = 1'b0;
        if16.a = '0;
        if16.b = '0;
        if16.out_ready = 1'b0;
        if256.in_valid = 1'b0;
        if256.a = '0;
        if256.b = '0;
        if256.out_ready = 1'b0;

        #2;
        check("rst_irdy", v_t'(if16.in_ready), v_t'(1));
        check("rst_ov", v_t'(if16.out_valid), v_t'(0));
        check("rst_busy", v_t'(if16.busy), v_t'(0));
        check("rst_prod", v_t'(if16.product), v_t'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        send16(16'h1234, 16'h5678, 32'h06260060);
        recv16("basic", LAT);

        // out_ready already high before out_valid
        if16.out_ready = 1'b1;
        send16(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        recv16("ones", LAT);

        send16(16'hABCD, 16'h0000, 32'h0);
        recv16("b0", SKIP ? 2 : LAT);

        send16(16'hABCD, 16'h0003, 32'h00020367);
        recv16("b3", SKIP ? 2 : LAT);

        send16(16'h0000, 16'h1234, 32'h0);
        recv16("a0", SKIP ? 2 : LAT);

        // backpressure with junk in_valid held throughout the stall
        send16(16'h00FF, 16'h0101, 32'h0000FFFF);
        if16.in_valid = 1'b1;
        if16.a = 16'h1111;
        if16.b = 16'h2222;
        wait16("bp", LAT);
        pop16("bp", exp);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_prod", v_t'(if16.product), v_t'(exp));
            check("bp_hold_ov", v_t'(if16.out_valid), v_t'(1));
            check("bp_hold_irdy", v_t'(if16.in_ready), v_t'(0));
        end
        if16.a = 16'h0007;
        if16.b = 16'h0009;
        if16.out_ready = 1'b1;
        check("bp_prod", v_t'(if16.product), v_t'(exp));
        @(posedge clk);
        #1 if16.out_ready = 1'b0;
        check("bp_ov_drop", v_t'(if16.out_valid), v_t'(0));
        check("bp_irdy_back", v_t'(if16.in_ready), v_t'(1));
        q16.push_back(32'd63);
        @(posedge clk);
        #1 if16.in_valid = 1'b0;
        recv16("bp_next", LAT);

        // reset in the second MULT cycle
        send16(16'h1234, 16'h5678, 32'h06260060);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_irdy", v_t'(if16.in_ready), v_t'(1));
        check("abort_ov", v_t'(if16.out_valid), v_t'(0));
        check("abort_prod", v_t'(if16.product), v_t'(0));
        check("abort_busy", v_t'(if16.busy), v_t'(0));
        q16.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send16(16'h0003, 16'h0005, 32'd15);
        recv16("after_rst", LAT);

        if256.out_ready = 1'b1;
        fork
            drive256();
            mon256();
        join

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
